// File: rtl/qdiv_seq_if.sv
// Operand/result bundle for the sequential fixed-point divider.
// The master side issues work and the slave side returns results.
interface qdiv_seq_if #(
    parameter int N = 16
);
    logic         i_start;
    logic [N-1:0] i_dividend;
    logic [N-1:0] i_divisor;
    logic [N-1:0] o_quotient;
    logic         o_busy;
    logic         o_done;
    logic         o_ovr;
    logic         o_dbz;

    modport master (
        output i_start, i_dividend, i_divisor,
        input  o_quotient, o_busy, o_done, o_ovr, o_dbz
    );

    modport slave (
        input  i_start, i_dividend, i_divisor,
        output o_quotient, o_busy, o_done, o_ovr, o_dbz
    );
endinterface

// File: rtl/qdiv_seq.sv
// Signed Q-format divider, restoring algorithm, one quotient bit per cycle.
// Magnitudes are divided unsigned; sign and saturation are applied at the end.
module qdiv_seq #(
    parameter int Q = 8,
    parameter int N = 16
) (
    input logic     i_clk,
    input logic     i_rst_n,
    qdiv_seq_if.slave bus
);
    localparam int W  = N + Q;
    localparam int CW = $clog2(W + 1);
    localparam logic [N-1:0] MAX_P = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MIN_P = {1'b1, {(N-2){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic          accept;
    logic          zero_div;
    logic [N-1:0]  mag_a;
    logic [N-1:0]  mag_b;
    logic [W-1:0]  num;
    logic [W-1:0]  quo;
    logic [N:0]    rem;
    logic [N-1:0]  div;
    logic [CW-1:0] cnt;
    logic          sign;
    logic          a_neg;
    logic          dbz_f;
    logic [N:0]    rem_sh;
    logic [N:0]    rem_sub;
    logic          q_bit;
    logic [N-1:0]  res_q;
    logic          res_ovr;

    assign accept   = bus.i_start && (state != CALC);
    assign zero_div = (bus.i_divisor == '0);
    assign mag_a    = bus.i_dividend[N-1] ? -bus.i_dividend : bus.i_dividend;
    assign mag_b    = bus.i_divisor[N-1]  ? -bus.i_divisor  : bus.i_divisor;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = zero_div ? DONE : CALC;
            CALC: if (cnt == CW'(W - 1)) state_nx = DONE;
            DONE: begin
                if (accept) state_nx = zero_div ? DONE : CALC;
                else        state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Shifted partial remainder needs one extra bit before the compare.
    assign rem_sh  = {rem[N-1:0], num[W-1]};
    assign rem_sub = rem_sh - {1'b0, div};
    assign q_bit   = (rem_sh >= {1'b0, div});

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            num   <= '0;
            quo   <= '0;
            rem   <= '0;
            div   <= '0;
            cnt   <= '0;
            sign  <= 1'b0;
            a_neg <= 1'b0;
            dbz_f <= 1'b0;
        end else if (accept) begin
            num   <= {mag_a, {Q{1'b0}}};
            quo   <= '0;
            rem   <= '0;
            div   <= mag_b;
            cnt   <= '0;
            sign  <= bus.i_dividend[N-1] ^ bus.i_divisor[N-1];
            a_neg <= bus.i_dividend[N-1];
            dbz_f <= zero_div;
        end else if (state == CALC) begin
            num <= num << 1;
            rem <= q_bit ? rem_sub : rem_sh;
            quo <= {quo[W-2:0], q_bit};
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        bus.o_busy = (state == CALC);
        res_ovr    = |quo[W-1:N-1];
        res_q      = sign ? -quo[N-1:0] : quo[N-1:0];
        if (dbz_f) begin
            res_ovr = 1'b0;
            res_q   = a_neg ? MIN_P : MAX_P;
        end else if (res_ovr) begin
            res_q = sign ? MIN_P : MAX_P;
        end
    end

    // Results are published one cycle after DONE; that edge wins over a clear.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bus.o_quotient <= '0;
            bus.o_done     <= 1'b0;
            bus.o_ovr      <= 1'b0;
            bus.o_dbz      <= 1'b0;
        end else begin
            bus.o_done <= (state == DONE);
            if (state == DONE) begin
                bus.o_quotient <= res_q;
                bus.o_ovr      <= res_ovr;
                bus.o_dbz      <= dbz_f;
            end else if (accept) begin
                bus.o_ovr <= 1'b0;
                bus.o_dbz <= 1'b0;
            end
        end
    end
endmodule

// File: doc/qdiv_seq.md
QDIV_SEQ -- requirements
Module: qdiv_seq

Interface
REQ-001 The block SHALL have parameter Q, default 8, meaning the number of fractional bits.
REQ-002 The block SHALL have parameter N, default 16, meaning the total word width, two's complement.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 i_clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 i_rst_n  input  1  synchronous active-low reset.
REQ-006 i_start  input  1  request pulse; SHALL be sampled only while o_busy=0.
REQ-007 i_dividend  input  N  signed QN-Q.Q numerator.
REQ-008 i_divisor  input  N  signed QN-Q.Q denominator.
REQ-009 o_quotient  output  N  signed QN-Q.Q result; SHALL be held until the next accepted start or reset.
REQ-010 o_busy  output  1  high while a division is in progress.
REQ-011 o_done  output  1  one-cycle pulse marking a valid o_quotient.
REQ-012 o_ovr  output  1  quotient magnitude exceeded 2^(N-1)-1; held with o_quotient.
REQ-013 o_dbz  output  1  divisor was zero; held with o_quotient.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE; o_busy=1 only in CALC.
REQ-015 A start SHALL be accepted when i_start=1 in IDLE or DONE; i_start in CALC SHALL be ignored.
REQ-016 On accept, the block SHALL latch the sign (i_dividend[N-1] XOR i_divisor[N-1]) and both magnitudes as N-bit unsigned values (0x8000 -> 32768); later input changes SHALL have no effect.
REQ-017 On accept, the block SHALL clear o_ovr and o_dbz and hold the previous o_quotient.
REQ-018 The numerator SHALL be |dividend| shifted left by Q (N+Q bits), divided by |divisor| with restoring division, one quotient bit per cycle, MSB first.
REQ-019 CALC SHALL last exactly N+Q cycles, then enter DONE for one cycle, then return to IDLE unless a new start is accepted in DONE.
REQ-020 o_done SHALL be high exactly N+Q+1 rising edges after the accepting edge.
REQ-021 The magnitude result SHALL be truncated toward zero; the output SHALL be the two's complement negation of the magnitude when the sign is 1, and -0 SHALL yield 0x0000.
REQ-022 If any bit of the N+Q-bit magnitude at position N-1 or above is set, o_ovr SHALL be 1 and o_quotient SHALL saturate to 0x7FFF (sign 0) or 0x8001 (sign 1).
REQ-023 If the divisor is zero at accept, the block SHALL skip CALC and go to DONE on the next edge (o_done one cycle after accept).
REQ-024 In the divide-by-zero case, o_dbz SHALL be 1, o_ovr 0, and o_quotient 0x7FFF if the dividend is >= 0, else 0x8001.
REQ-025 o_quotient, o_ovr and o_dbz SHALL update only in the cycle o_done rises.

Reset
REQ-026 While i_rst_n=0 at a rising edge, the state SHALL become IDLE and o_quotient, o_busy, o_done, o_ovr and o_dbz SHALL all be 0.
REQ-027 A reset during CALC SHALL abort the division with no o_done pulse, and the next start SHALL behave as if from power-up.

Verification
REQ-028 Bench: 0x0180 / 0x0080 (1.5/0.5) -> o_done 25 cycles after accept, o_quotient 0x0300, o_ovr=0, o_busy high for 24 cycles.
REQ-029 Bench: 0xFD00 / 0x0200 -> 0xFE80; 0x0100 / 0x0300 -> 0x0055; 0xFF00 / 0x0300 -> 0xFFAB (truncation toward zero).
REQ-030 Bench: 0x7F00 / 0x0001 -> o_ovr=1, 0x7FFF; 0x8000 / 0x0100 -> o_ovr=1, 0x8001.
REQ-031 Bench: 0xFE00 / 0x0000 -> o_done 1 cycle after accept, o_dbz=1, 0x8001; then 0x0200 / 0x0000 -> 0x7FFF.
REQ-032 Bench: start, toggle i_start and the operands during CALC -> ignored, result of the original operands; start asserted in the DONE cycle -> accepted back-to-back.
REQ-033 Bench: assert i_rst_n=0 at cycle 10 of CALC -> all outputs 0 the next cycle, no o_done, and a following 0x0180 / 0x0080 gives 0x0300.
